// File: rtl/mem_bus_bridge.sv
// EX-to-external-bus bridge: one outstanding access, lane steering for stores and extension for loads.
// Optional ack timeout is compiled in with `define MEM_BUS_TIMEOUT_EN.
module mem_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_req_bus_i,
    input  logic [31:0] ex_mem_addr_i,
    input  logic        ex_mem_rw_i,
    input  logic [1:0]  ex_mem_width_i,
    input  logic        ex_mem_rdtype_i,
    input  logic [31:0] ex_mem_wr_data_i,
    output logic        bus_busy_o,
    output logic        bus_done_o,
    output logic        bus_err_o,
    output logic [31:0] bus_rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_wstrb_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic        bus_err_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic [1:0]  width_q;
    logic [1:0]  off_q;
    logic        rdtype_q;
    logic        misalign;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic        timeout;

    always_comb begin
        misalign = (ex_mem_width_i == 2'b11) ||
                   (ex_mem_width_i == 2'b01 && ex_mem_addr_i[0]) ||
                   (ex_mem_width_i == 2'b10 && ex_mem_addr_i[1:0] != 2'b00);
    end

    // Stores are replicated across lanes; the strobe selects which lanes the bus commits.
    always_comb begin
        strb_d  = 4'b1111;
        wdata_d = ex_mem_wr_data_i;
        case (ex_mem_width_i)
            2'b00: begin
                strb_d  = 4'b0001 << ex_mem_addr_i[1:0];
                wdata_d = {4{ex_mem_wr_data_i[7:0]}};
            end
            2'b01: begin
                strb_d  = 4'b0011 << ex_mem_addr_i[1:0];
                wdata_d = {2{ex_mem_wr_data_i[15:0]}};
            end
            default: ;
        endcase
        if (!ex_mem_rw_i)
            strb_d = 4'b0000;
    end

    always_comb begin
        shifted   = bus_rdata_i >> {off_q, 3'b000};
        load_data = bus_rdata_i;
        case (width_q)
            2'b00: load_data = rdtype_q ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: load_data = rdtype_q ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] to_cnt;

    // Counts ACCESS cycles without ack; fires in the TIMEOUT_CYCLES-th one.
    assign timeout = (to_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (state == IDLE && ex_req_bus_i)
            to_cnt <= '0;
        else if (state == ACCESS && !bus_ack_i)
            to_cnt <= to_cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    assign bus_busy_o = (state == ACCESS) || (state == IDLE && ex_req_bus_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            width_q     <= 2'b00;
            off_q       <= 2'b00;
            rdtype_q    <= 1'b0;
            bus_done_o  <= 1'b0;
            bus_err_o   <= 1'b0;
            bus_rdata_o <= 32'h0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= 32'h0;
            bus_wstrb_o <= 4'h0;
            bus_wdata_o <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_req_bus_i) begin
                        if (misalign) begin
                            state       <= DONE;
                            bus_done_o  <= 1'b1;
                            bus_err_o   <= 1'b1;
                            bus_rdata_o <= 32'h0;
                        end else begin
                            state       <= ACCESS;
                            width_q     <= ex_mem_width_i;
                            off_q       <= ex_mem_addr_i[1:0];
                            rdtype_q    <= ex_mem_rdtype_i;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= ex_mem_rw_i;
                            bus_addr_o  <= {ex_mem_addr_i[31:2], 2'b00};
                            bus_wstrb_o <= strb_d;
                            bus_wdata_o <= wdata_d;
                        end
                    end
                end
                ACCESS: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (bus_ack_i) begin
                        state       <= DONE;
                        bus_req_o   <= 1'b0;
                        bus_done_o  <= 1'b1;
                        bus_err_o   <= bus_err_i;
                        bus_rdata_o <= (bus_err_i || bus_we_o) ? 32'h0 : load_data;
                    end else if (timeout) begin
                        state       <= DONE;
                        bus_req_o   <= 1'b0;
                        bus_done_o  <= 1'b1;
                        bus_err_o   <= 1'b1;
                        bus_rdata_o <= 32'h0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    bus_done_o <= 1'b0;
                    bus_err_o  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: stimulus pushes expected completions, a negedge monitor checks them.
module tb_mem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_req_bus_i;
    logic [31:0] ex_mem_addr_i;
    logic        ex_mem_rw_i;
    logic [1:0]  ex_mem_width_i;
    logic        ex_mem_rdtype_i;
    logic [31:0] ex_mem_wr_data_i;
    logic        bus_busy_o, bus_done_o, bus_err_o;
    logic [31:0] bus_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i, bus_err_i;
    logic [31:0] bus_rdata_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   n_exp = 0;
    int   n_done = 0;

    mem_bus_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_req_bus_i(ex_req_bus_i), .ex_mem_addr_i(ex_mem_addr_i),
        .ex_mem_rw_i(ex_mem_rw_i), .ex_mem_width_i(ex_mem_width_i),
        .ex_mem_rdtype_i(ex_mem_rdtype_i), .ex_mem_wr_data_i(ex_mem_wr_data_i),
        .bus_busy_o(bus_busy_o), .bus_done_o(bus_done_o), .bus_err_o(bus_err_o),
        .bus_rdata_o(bus_rdata_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
        .bus_addr_o(bus_addr_o), .bus_wstrb_o(bus_wstrb_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && bus_done_o) begin
            exp_t e;
            n_done++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: rdata %h err %b with nothing pending", bus_rdata_o, bus_err_o);
            end else begin
                e = q.pop_front();
                chk("done_rdata", bus_rdata_o, e.rdata);
                chk("done_err", {31'h0, bus_err_o}, {31'h0, e.err});
                chk("done_busy", {31'h0, bus_busy_o}, 32'h0);
                chk("done_req", {31'h0, bus_req_o}, 32'h0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with the bridge back in IDLE.
    task automatic issue(input logic [31:0] addr, input logic rw, input logic [1:0] w,
                         input logic rdt, input logic [31:0] wd, input int dly,
                         input logic [31:0] ack_rd, input logic ack_err, input logic mis,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input logic exp_err, input logic poke);
        ex_req_bus_i = 1'b1;
        ex_mem_addr_i = addr;
        ex_mem_rw_i = rw;
        ex_mem_width_i = w;
        ex_mem_rdtype_i = rdt;
        ex_mem_wr_data_i = wd;
        q.push_back('{exp_rd, exp_err});
        n_exp++;
        #1;
        chk("busy_on_req", {31'h0, bus_busy_o}, 32'h1);
        @(posedge clk);
        #1;
        ex_req_bus_i = 1'b0;
        if (mis) begin
            chk("misalign_no_req", {31'h0, bus_req_o}, 32'h0);
        end else begin
            for (int i = 0; i <= dly; i++) begin
                chk("access_req", {31'h0, bus_req_o}, 32'h1);
                chk("access_addr", bus_addr_o, {addr[31:2], 2'b00});
                chk("access_strb", {28'h0, bus_wstrb_o}, {28'h0, exp_strb});
                chk("access_we", {31'h0, bus_we_o}, {31'h0, rw});
                chk("access_busy", {31'h0, bus_busy_o}, 32'h1);
                if (rw)
                    chk("access_wdata", bus_wdata_o, exp_wd);
                if (i < dly) begin
                    if (poke) begin
                        ex_req_bus_i = 1'b1;
                        ex_mem_addr_i = 32'h2000_0100;
                    end
                    @(posedge clk);
                    #1;
                    ex_req_bus_i = 1'b0;
                end
            end
            bus_ack_i = 1'b1;
            bus_err_i = ack_err;
            bus_rdata_i = ack_rd;
            @(posedge clk);
            #1;
            bus_ack_i = 1'b0;
            bus_err_i = 1'b0;
            bus_rdata_i = 32'h5A5A_5A5A;
            chk("req_drop", {31'h0, bus_req_o}, 32'h0);
        end
        @(posedge clk);
        #1;
        chk("done_pulse_end", {31'h0, bus_done_o}, 32'h0);
        chk("err_idle", {31'h0, bus_err_o}, 32'h0);
        chk("rdata_hold", bus_rdata_o, exp_rd);
    endtask

    initial begin
        rst_n = 1'b0;
        ex_req_bus_i = 1'b0;
        ex_mem_addr_i = 32'h0;
        ex_mem_rw_i = 1'b0;
        ex_mem_width_i = 2'b00;
        ex_mem_rdtype_i = 1'b0;
        ex_mem_wr_data_i = 32'h0;
        bus_ack_i = 1'b0;
        bus_err_i = 1'b0;
        bus_rdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'h0, bus_req_o}, 32'h0);
        chk("rst_done", {31'h0, bus_done_o}, 32'h0);
        chk("rst_rdata", bus_rdata_o, 32'h0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_busy", {31'h0, bus_busy_o}, 32'h0);
        rst_n = 1'b1;

        //     addr          rw    w      rdt   wdata         dly ack_rd        aerr  mis   strb     exp_wd        exp_rd        eerr  poke
        issue(32'h2000_0004, 1'b0, 2'b10, 1'b0, 32'h0,        2, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0);
        issue(32'h2000_0003, 1'b0, 2'b00, 1'b0, 32'h0,        0, 32'h8000_0000, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0);
        issue(32'h2000_0003, 1'b0, 2'b00, 1'b1, 32'h0,        0, 32'h8000_0000, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_0080, 1'b0, 1'b0);
        issue(32'h2000_0002, 1'b1, 2'b01, 1'b0, 32'h0000_1234, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b1100, 32'h1234_1234, 32'h0,        1'b0, 1'b1);
        issue(32'h2000_0001, 1'b0, 2'b10, 1'b0, 32'h0,        0, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
        issue(32'h2000_0002, 1'b0, 2'b01, 1'b0, 32'h0,        1, 32'h8001_1111, 1'b0, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0);
        issue(32'h2000_0005, 1'b1, 2'b00, 1'b0, 32'hFFFF_FFA5, 0, 32'h0,        1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0);
        issue(32'h2000_0008, 1'b1, 2'b10, 1'b0, 32'hCAFE_F00D, 3, 32'h0,        1'b0, 1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0);
        issue(32'h2000_000C, 1'b0, 2'b10, 1'b0, 32'h0,        1, 32'h1234_5678, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
        issue(32'h2000_0000, 1'b0, 2'b11, 1'b0, 32'h0,        0, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
        issue(32'h2000_0001, 1'b1, 2'b01, 1'b0, 32'h0000_BEEF, 0, 32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
        issue(32'h2000_0000, 1'b0, 2'b01, 1'b1, 32'h0,        0, 32'h1234_F00F, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000_F00F, 1'b0, 1'b0);

        // Reset mid-ACCESS: bus request drops at once and no completion appears.
        ex_req_bus_i = 1'b1;
        ex_mem_addr_i = 32'h2000_0010;
        ex_mem_rw_i = 1'b0;
        ex_mem_width_i = 2'b10;
        @(posedge clk);
        #1;
        ex_req_bus_i = 1'b0;
        chk("pre_rst_req", {31'h0, bus_req_o}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'h0, bus_req_o}, 32'h0);
        chk("async_rst_busy", {31'h0, bus_busy_o}, 32'h0);
        chk("async_rst_addr", bus_addr_o, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(32'h2000_0014, 1'b0, 2'b10, 1'b0, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0);

`ifdef MEM_BUS_TIMEOUT_EN
        begin
            int n;
            ex_req_bus_i = 1'b1;
            ex_mem_addr_i = 32'h2000_0020;
            ex_mem_rw_i = 1'b0;
            ex_mem_width_i = 2'b10;
            q.push_back('{32'h0, 1'b1});
            n_exp++;
            @(posedge clk);
            #1;
            ex_req_bus_i = 1'b0;
            n = 0;
            while (bus_req_o && n < 20) begin
                n++;
                @(posedge clk);
                #1;
            end
            chk("timeout_req_cycles", n, 4);
            @(posedge clk);
            #1;
        end
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("done_count", n_done, n_exp);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
